// File: rtl/scs8hd_exerciser_pkg.sv
// Shared types and vector mapping for the a3xxoi cell exercisers.
// Vector bit order on the cell pins is {C1,B1,A3,A2,A1}.
package scs8hd_exerciser_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_e;

  localparam int NUM_VECTORS = 32;
  localparam int VEC_W       = 5;

  localparam int VEC_A1 = 0;
  localparam int VEC_A2 = 1;
  localparam int VEC_A3 = 2;
  localparam int VEC_B1 = 3;
  localparam int VEC_C1 = 4;

  localparam logic [VEC_W-1:0] LAST_VEC =
    VEC_W'(NUM_VECTORS - 1);

endpackage

// File: rtl/scs8hd_a311oi_golden.sv
// Expected output of an a311oi cell for one input vector:
// Y = !((A1 & A2 & A3) | B1 | C1).
module scs8hd_a311oi_golden
  import scs8hd_exerciser_pkg::*;
(
  input  logic [VEC_W-1:0] i_vec,
  output logic             o_exp
);

  logic w_and3;

  assign w_and3 = i_vec[VEC_A3]
                & i_vec[VEC_A2]
                & i_vec[VEC_A1];

  assign o_exp = !(w_and3
                 | i_vec[VEC_B1]
                 | i_vec[VEC_C1]);

endmodule

// File: rtl/scs8hd_a311oi_exerciser.sv
// Walks all 32 a311oi input vectors, holds each to let the cell
// settle, samples Y_IN and records error count and first failure.
module scs8hd_a311oi_exerciser
  import scs8hd_exerciser_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 6
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  output logic             A1,
  output logic             A2,
  output logic             A3,
  output logic             B1,
  output logic             C1,
  input  logic             Y_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [ERR_W-1:0] ERR_COUNT,
  output logic             FAIL_VALID,
  output logic [VEC_W-1:0] FAIL_VEC
);

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_e           r_state;
  logic [VEC_W-1:0] r_vec;
  logic [3:0]       r_cnt;
  logic [VEC_W-1:0] r_stim;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [ERR_W-1:0] r_err;
  logic             r_fvalid;
  logic [VEC_W-1:0] r_fvec;

  logic             w_exp;
  logic             w_mis;
  logic [ERR_W-1:0] w_err_nx;

  scs8hd_a311oi_golden u_golden (
    .i_vec (r_vec),
    .o_exp (w_exp)
  );

  // Case inequality so an X/Z from the cell counts as a failure.
  assign w_mis = (Y_IN !== w_exp);

  assign w_err_nx = (w_mis && !(&r_err))
                  ? r_err + ERR_W'(1)
                  : r_err;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state  <= S_IDLE;
      r_vec    <= '0;
      r_cnt    <= '0;
      r_stim   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
      r_err    <= '0;
      r_fvalid <= 1'b0;
      r_fvec   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (START) begin
            r_state  <= S_SETTLE;
            r_vec    <= '0;
            r_cnt    <= '0;
            r_stim   <= '0;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_err    <= '0;
            r_fvalid <= 1'b0;
            r_fvec   <= '0;
          end
        end
        S_SETTLE: begin
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == CNT_LAST)
            r_state <= S_SAMPLE;
        end
        S_SAMPLE: begin
          r_err <= w_err_nx;
          if (w_mis && !r_fvalid) begin
            r_fvec   <= r_vec;
            r_fvalid <= 1'b1;
          end
          if (r_vec == LAST_VEC) begin
            r_state <= S_DONE;
            r_stim  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_nx == '0);
          end else begin
            r_state <= S_SETTLE;
            r_vec   <= r_vec + VEC_W'(1);
            r_stim  <= r_vec + VEC_W'(1);
            r_cnt   <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign A1         = r_stim[VEC_A1];
  assign A2         = r_stim[VEC_A2];
  assign A3         = r_stim[VEC_A3];
  assign B1         = r_stim[VEC_B1];
  assign C1         = r_stim[VEC_C1];
  assign BUSY       = r_busy;
  assign DONE       = r_done;
  assign PASS       = r_pass;
  assign ERR_COUNT  = r_err;
  assign FAIL_VALID = r_fvalid;
  assign FAIL_VEC   = r_fvec;

endmodule

// File: doc/scs8hd_a311oi_exerciser.md
# scs8hd_a311oi_exerciser

Self-test driver/checker for the a311oi cell, Y = !((A1 & A2 & A3) | B1 | C1). The exerciser drives all 32 input combinations into a cell instance and samples the cell's Y back. It compares each sample against a golden model and reports pass/fail, an error count and the first failing vector. It sits beside the cell in library bring-up and silicon-monitor wrappers, on the input side of the cell.

## Interface
- SETTLE_CYCLES, 2: cycles each vector is held before Y is sampled; legal range 1..15.
- ERR_W, 6: width of ERR_COUNT.

- CLK  input  1  single clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- START  input  1  run request, single-cycle pulse or level; sampled only in IDLE or DONE.
- A1, A2, A3, B1, C1  output  1 each  registered stimulus to the cell.
- Y_IN  input  1  cell output under test.
- BUSY  output  1  high in SETTLE and SAMPLE.
- DONE  output  1  high in DONE state.
- PASS  output  1  valid when DONE is high; 1 when ERR_COUNT == 0.
- ERR_COUNT  output  ERR_W  mismatch count for the last run.
- FAIL_VALID  output  1  at least one mismatch in the current or last run.
- FAIL_VEC  output  5  first mismatching vector, encoded {C1,B1,A3,A2,A1}.

## Operation
- Vector index `vec[4:0]` counts 0→31. Stimulus mapping: {C1,B1,A3,A2,A1} = vec.
- Expected value: exp = !((vec[2] & vec[1] & vec[0]) | vec[3] | vec[4]). Exactly 7 of the 32 vectors expect 1: vec 0..6.
- **IDLE**
  - Stimulus, BUSY, DONE and PASS are 0; ERR_COUNT, FAIL_VALID and FAIL_VEC hold their values.
  - START=1: go to SETTLE, vec=0, settle counter=0, ERR_COUNT=0, FAIL_VALID=0, FAIL_VEC=0.
- **SETTLE**
  - Stimulus = vec. The counter increments each cycle.
  - When the counter reaches SETTLE_CYCLES-1, go to SAMPLE.
- **SAMPLE**
  - Stimulus = vec. Y_IN is compared with exp.
  - On mismatch: ERR_COUNT increments, saturating at 2^ERR_W-1. If FAIL_VALID=0, set FAIL_VEC=vec and FAIL_VALID=1.
  - If vec==31, go to DONE. Otherwise vec=vec+1, counter=0, go to SETTLE.
- **DONE**
  - Stimulus = 0. DONE=1 and PASS = (ERR_COUNT==0). Results hold.
  - START=1: restart exactly as from IDLE, clearing the results.
- START while BUSY is ignored. It does not queue.
- vec never wraps during a run. The 31→0 transition happens only through a new START.
- X or Z on Y_IN during SAMPLE counts as a mismatch (case-inequality compare).

## Timing
- Reset (synchronous): state=IDLE; all outputs 0, including A1..C1, ERR_COUNT, FAIL_VALID and FAIL_VEC. Reset wins over START in the same cycle.
- Reset asserted mid-run: IDLE on the next edge. Partial results are discarded.
- START high at edge t: the cycle after t is in SETTLE with vec 0 driven.
- Each vector occupies SETTLE_CYCLES+1 cycles. Y_IN is sampled on the edge ending its SAMPLE cycle, after the vector has been stable for SETTLE_CYCLES+1 cycles.
- DONE rises 32·(SETTLE_CYCLES+1) cycles after the START edge: 96 cycles at default.
- Stimulus changes only on the edge that leaves SAMPLE, or on the edge entering and leaving a run. There are no glitches: all stimulus comes straight from flops.

## Structure
- Shared package `scs8hd_exerciser_pkg` holds:
  - the state enum {IDLE, SETTLE, SAMPLE, DONE};
  - NUM_VECTORS=32;
  - the vector-field mapping constants.
- Sub-module `scs8hd_a311oi_golden`: a combinational expected-value model taking a 5-bit vec and producing exp. It is reused by sibling exercisers for other a3xxoi cells.
- The cell under test is instantiated outside the exerciser, by the wrapper or bench.

## Test plan
- **Good cell, default parameters:** reset, then START for 1 cycle → after 96 cycles DONE=1, PASS=1, ERR_COUNT=0, FAIL_VALID=0. The stimulus trace shows vec 0..31, each held 3 cycles.
- **Stuck-at-1 Y_IN:** → ERR_COUNT=25, FAIL_VEC=7, PASS=0.
- **Stuck-at-0 Y_IN:** → ERR_COUNT=7, FAIL_VEC=0.
- **Saturation:** ERR_W=3 with inverted Y_IN → ERR_COUNT=7 (saturated), FAIL_VEC=0.
- **Control boundaries:**
  - START pulses during BUSY do not shift the DONE time.
  - RESET at cycle 40 → IDLE with all outputs 0 on the next cycle.
  - START in DONE restarts with the results cleared.
- **SETTLE_CYCLES=1:** DONE at 64 cycles. A model cell with a 1-cycle output delay still passes; a 2-cycle delay fails with FAIL_VEC=0, because vec 0 is sampled after only 2 stable cycles while the delayed output still shows its reset value of 0.
